// File: rtl/w_shift_unit_pkg.sv
// Shared types, constants and helpers for the LCD W-shifter.
package w_unit_pkg;

    localparam int MAX_DEPTH = 15;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_SHIFT = 3'd1,
        OP_DTW   = 3'd2,
        OP_PDTW  = 3'd3,
        OP_TW    = 3'd4,
        OP_PTW   = 3'd5,
        OP_CLR   = 3'd6,
        OP_RSVD  = 3'd7
    } w_op_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_PLA_WAIT = 1'b1
    } w_state_e;

    // Segment-digit PLA, indexed by {lcd_cn, acc}
    localparam logic [3:0] PLA_TABLE [32] = '{
        4'he, 4'h0, 4'hc, 4'h8, 4'h2, 4'ha, 4'he, 4'h2,
        4'he, 4'ha, 4'h0, 4'h0, 4'h2, 4'ha, 4'h2, 4'h2,
        4'hb, 4'h9, 4'h7, 4'hf, 4'hd, 4'he, 4'he, 4'hb,
        4'hf, 4'hf, 4'h4, 4'h0, 4'hd, 4'he, 4'h4, 4'h0
    };

    // Out-of-range lengths fall back to the full physical depth
    function automatic logic [3:0] eff_len(input logic [3:0] wl, input int depth);
        if (wl >= 4'd2 && int'(wl) <= depth)
            return wl;
        else
            return 4'(depth);
    endfunction

endpackage

// File: rtl/w_shift_unit_if.sv
// Op request bus between the instruction decoder and the W-shifter.
interface w_shift_unit_if #(
    parameter int NIBBLE_WIDTH = 4
);
    logic                    op_valid;
    logic                    op_ready;
    logic [2:0]              op;
    logic [3:0]              w_length;
    logic [NIBBLE_WIDTH-1:0] shift_in;
    logic [3:0]              acc;
    logic                    lcd_cn;
    logic                    m_prime;

    modport master (
        output op_valid, op, w_length, shift_in, acc, lcd_cn, m_prime,
        input  op_ready
    );

    modport slave (
        input  op_valid, op, w_length, shift_in, acc, lcd_cn, m_prime,
        output op_ready
    );
endinterface

// File: rtl/w_shift_unit_pla_rom.sv
// Registered 32x4 segment-digit lookup.
module w_pla_rom
    import w_unit_pkg::*;
(
    input  logic       clk,
    input  logic [4:0] addr,
    output logic [3:0] data
);

    // One-cycle registered read
    always_ff @(posedge clk) begin
        data <= PLA_TABLE[addr];
    end

endmodule

// File: rtl/w_shift_unit.sv
// W/W' register pair with shift/PLA/copy ops and a free-running scan engine.
module w_shift_unit
    import w_unit_pkg::*;
#(
    parameter int NIBBLE_WIDTH = 4,
    parameter int DEPTH        = 9
) (
    input  logic                          clk,
    input  logic                          reset,
    w_shift_unit_if.slave                 bus,
    input  logic                          scan_tick,
    output logic [DEPTH*NIBBLE_WIDTH-1:0] w_main_flat,
    output logic [DEPTH*NIBBLE_WIDTH-1:0] w_prime_flat,
    output logic [NIBBLE_WIDTH-1:0]       scan_data,
    output logic [3:0]                    scan_idx,
    output logic                          scan_valid
);

    localparam int  NW     = NIBBLE_WIDTH;
    localparam bit  PLA_EN = (NIBBLE_WIDTH == 4);

    w_state_e          state, state_next;
    w_op_e             op_in;
    logic              accept;
    logic              is_pla;
    logic [3:0]        len_in;
    logic [3:0]        len_q;
    logic [3:0]        pend_len;
    logic              pend_pdtw;
    logic              pend_or;
    logic [3:0]        rom_data;
    logic [3:0]        digit;

    logic [NW-1:0]     w_main  [DEPTH];
    logic [NW-1:0]     w_prime [DEPTH];
    logic [NW-1:0]     wm_next [DEPTH];
    logic [NW-1:0]     wp_next [DEPTH];

    logic              do_shift;
    logic [NW-1:0]     shift_v;
    logic [3:0]        wr_len;

    logic [3:0]        scan_ptr;
    logic [3:0]        scan_cur;
    logic [NW-1:0]     scan_word;

    assign op_in  = w_op_e'(bus.op);
    assign len_in = eff_len(bus.w_length, DEPTH);
    assign accept = bus.op_valid && (state == ST_IDLE);
    assign is_pla = PLA_EN && (op_in == OP_DTW || op_in == OP_PDTW);
    assign digit  = rom_data | {3'b000, pend_or};

    w_pla_rom u_pla_rom (
        .clk  (clk),
        .addr ({bus.lcd_cn, bus.acc}),
        .data (rom_data)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // FSM next state and handshake
    always_comb begin
        state_next   = state;
        bus.op_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.op_ready = 1'b1;
                if (accept && is_pla)
                    state_next = ST_PLA_WAIT;
            end
            ST_PLA_WAIT: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture op fields at acceptance so late input changes cannot leak in
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q     <= 4'(DEPTH);
            pend_len  <= 4'(DEPTH);
            pend_pdtw <= 1'b0;
            pend_or   <= 1'b0;
        end else if (accept) begin
            len_q <= len_in;
            if (is_pla) begin
                pend_len  <= len_in;
                pend_pdtw <= (op_in == OP_PDTW);
                pend_or   <= ~bus.lcd_cn & bus.m_prime;
            end
        end
    end

    // Next-value computation for W and W'
    always_comb begin
        wm_next  = w_main;
        wp_next  = w_prime;
        do_shift = 1'b0;
        shift_v  = '0;
        wr_len   = len_in;
        if (state == ST_PLA_WAIT) begin
            wr_len = pend_len;
            if (pend_pdtw) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (i == int'(wr_len) - 2) wp_next[i] = w_prime[i+1];
                    if (i == int'(wr_len) - 1) wp_next[i] = digit[NW-1:0];
                end
            end else begin
                do_shift = 1'b1;
                shift_v  = digit[NW-1:0];
            end
        end else if (accept) begin
            case (op_in)
                OP_SHIFT: begin
                    do_shift = 1'b1;
                    shift_v  = bus.shift_in;
                end
                OP_TW: begin
                    for (int i = 0; i < DEPTH; i++)
                        if (i < int'(wr_len)) wm_next[i] = w_prime[i];
                end
                OP_PTW: begin
                    for (int i = 0; i < DEPTH; i++)
                        if (i == int'(wr_len) - 1 || i == int'(wr_len) - 2)
                            wm_next[i] = w_prime[i];
                end
                OP_CLR: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        wm_next[i] = '0;
                        wp_next[i] = '0;
                    end
                end
                default: ;
            endcase
        end
        if (do_shift) begin
            for (int i = 0; i < DEPTH - 1; i++)
                if (i < int'(wr_len) - 1) wp_next[i] = w_prime[i+1];
            for (int i = 0; i < DEPTH; i++)
                if (i == int'(wr_len) - 1) wp_next[i] = shift_v;
        end
    end

    // W and W' storage
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_main[i]  <= '0;
                w_prime[i] <= '0;
            end
        end else begin
            w_main  <= wm_next;
            w_prime <= wp_next;
        end
    end

    // Scan pointer clamp and entry select from the pre-op W
    always_comb begin
        scan_cur  = (scan_ptr >= len_q) ? 4'd0 : scan_ptr;
        scan_word = '0;
        for (int i = 0; i < DEPTH; i++)
            if (i == int'(scan_cur)) scan_word = w_main[i];
    end

    // Scan engine
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_ptr   <= 4'd0;
            scan_data  <= '0;
            scan_idx   <= 4'd0;
            scan_valid <= 1'b0;
        end else begin
            scan_valid <= scan_tick;
            if (scan_tick) begin
                scan_data <= scan_word;
                scan_idx  <= scan_cur;
                scan_ptr  <= (scan_cur == len_q - 4'd1) ? 4'd0 : scan_cur + 4'd1;
            end
        end
    end

    // Flatten the arrays onto the output buses
    always_comb begin
        w_main_flat  = '0;
        w_prime_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_main_flat[i*NW +: NW]  = w_main[i];
            w_prime_flat[i*NW +: NW] = w_prime[i];
        end
    end

endmodule

// File: tb/tb_w_shift_unit.sv
// Directed bench for the W-shifter in nibble (4x9) and binary (1x8) configurations.
module tb_w_shift_unit;
    import w_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic scan_tick4, scan_tick1;

    logic [35:0] wm4, wp4;
    logic [3:0]  sd4;
    logic [3:0]  si4;
    logic        sv4;
    logic [7:0]  wm1, wp1;
    logic [0:0]  sd1;
    logic [3:0]  si1;
    logic        sv1;

    int total = 0;
    int bad   = 0;

    w_shift_unit_if #(.NIBBLE_WIDTH(4)) if4 ();
    w_shift_unit_if #(.NIBBLE_WIDTH(1)) if1 ();

    w_shift_unit #(.NIBBLE_WIDTH(4), .DEPTH(9)) u4 (
        .clk (clk), .reset (reset), .bus (if4), .scan_tick (scan_tick4),
        .w_main_flat (wm4), .w_prime_flat (wp4),
        .scan_data (sd4), .scan_idx (si4), .scan_valid (sv4)
    );

    w_shift_unit #(.NIBBLE_WIDTH(1), .DEPTH(8)) u1 (
        .clk (clk), .reset (reset), .bus (if1), .scan_tick (scan_tick1),
        .w_main_flat (wm1), .w_prime_flat (wp1),
        .scan_data (sd1), .scan_idx (si1), .scan_valid (sv1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for one clock on the selected unit (0: nibble, 1: binary)
    task automatic do_op(input int sel, input logic [2:0] op, input logic [3:0] wl,
                         input logic [3:0] sin, input logic [3:0] acc,
                         input logic cn, input logic mp);
        if (sel == 0) begin
            if4.op = op; if4.w_length = wl; if4.shift_in = sin;
            if4.acc = acc; if4.lcd_cn = cn; if4.m_prime = mp; if4.op_valid = 1'b1;
        end else begin
            if1.op = op; if1.w_length = wl; if1.shift_in = sin[0];
            if1.acc = acc; if1.lcd_cn = cn; if1.m_prime = mp; if1.op_valid = 1'b1;
        end
        step();
        if4.op_valid = 1'b0;
        if1.op_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        scan_tick4 = 1'b0; scan_tick1 = 1'b0;
        if4.op_valid = 1'b0; if4.op = 3'd0; if4.w_length = 4'd9; if4.shift_in = 4'd0;
        if4.acc = 4'd0; if4.lcd_cn = 1'b0; if4.m_prime = 1'b0;
        if1.op_valid = 1'b0; if1.op = 3'd0; if1.w_length = 4'd8; if1.shift_in = 1'b0;
        if1.acc = 4'd0; if1.lcd_cn = 1'b0; if1.m_prime = 1'b0;
        step(); step();
        reset = 1'b0;

        chk("rst_wm4", 64'(wm4), 64'h0);
        chk("rst_wp4", 64'(wp4), 64'h0);
        chk("rst_rdy4", 64'(if4.op_ready), 64'h1);
        chk("rst_sv4", 64'(sv4), 64'h0);
        chk("rst_wp1", 64'(wp1), 64'h0);

        // SHIFT 1..9 with L=9
        for (int v = 1; v <= 9; v++) do_op(0, OP_SHIFT, 4'd9, 4'(v), 4'd0, 1'b0, 1'b0);
        chk("shift9_wp", 64'(wp4), 64'h987654321);
        chk("shift9_wm", 64'(wm4), 64'h0);

        do_op(0, OP_TW, 4'd9, 4'd0, 4'd0, 1'b0, 1'b0);
        chk("tw_wm", 64'(wm4), 64'h987654321);

        // DTW: PLA[3]=8 OR 1 -> 9; hold a CLR and flip m_prime during the wait
        do_op(0, OP_DTW, 4'd9, 4'd0, 4'd3, 1'b0, 1'b1);
        chk("dtw_rdy_low", 64'(if4.op_ready), 64'h0);
        chk("dtw_wp_hold", 64'(wp4), 64'h987654321);
        if4.op = OP_CLR; if4.op_valid = 1'b1; if4.m_prime = 1'b0; if4.acc = 4'hf;
        step();
        if4.op_valid = 1'b0;
        chk("dtw_rdy_back", 64'(if4.op_ready), 64'h1);
        chk("dtw_wp", 64'(wp4), 64'h998765432);
        chk("dtw_wm_kept", 64'(wm4), 64'h987654321);

        // PDTW at index 16 (digit b), L=4
        do_op(0, OP_PDTW, 4'd4, 4'd0, 4'd0, 1'b1, 1'b1);
        chk("pdtw_rdy_low", 64'(if4.op_ready), 64'h0);
        step();
        chk("pdtw_rdy_back", 64'(if4.op_ready), 64'h1);
        chk("pdtw_wp", 64'(wp4), 64'h99876b532);

        // Out-of-range lengths behave as full depth
        do_op(0, OP_SHIFT, 4'd1, 4'hf, 4'd0, 1'b0, 1'b0);
        chk("len1_wp", 64'(wp4), 64'hf99876b53);
        do_op(0, OP_SHIFT, 4'd12, 4'h0, 4'd0, 1'b0, 1'b0);
        chk("len12_wp", 64'(wp4), 64'h0f99876b5);

        // PTW L=4 copies entries 2 and 3 only
        do_op(0, OP_PTW, 4'd4, 4'd0, 4'd0, 1'b0, 1'b0);
        chk("ptw_wm", 64'(wm4), 64'h987657621);

        // Binary unit: SHIFT 1,0,1 then DTW no-op
        do_op(1, OP_SHIFT, 4'd8, 4'd1, 4'd0, 1'b0, 1'b0);
        do_op(1, OP_SHIFT, 4'd8, 4'd0, 4'd0, 1'b0, 1'b0);
        do_op(1, OP_SHIFT, 4'd8, 4'd1, 4'd0, 1'b0, 1'b0);
        chk("nw1_shift_wp", 64'(wp1), 64'ha0);
        do_op(1, OP_DTW, 4'd8, 4'd0, 4'd3, 1'b0, 1'b1);
        chk("nw1_dtw_rdy", 64'(if1.op_ready), 64'h1);
        chk("nw1_dtw_wp", 64'(wp1), 64'ha0);
        step();
        chk("nw1_dtw_wp2", 64'(wp1), 64'ha0);

        // Load {a,b,c,d,e} with L=5 and copy to W
        for (int v = 10; v <= 14; v++) do_op(0, OP_SHIFT, 4'd5, 4'(v), 4'd0, 1'b0, 1'b0);
        chk("l5_wp", 64'(wp4), 64'h0f99edcba);
        do_op(0, OP_TW, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0);
        chk("l5_tw_wm", 64'(wm4), 64'h9876edcba);

        // Twelve consecutive scan ticks
        scan_tick4 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk($sformatf("scan_valid_%0d", k), 64'(sv4), 64'h1);
            chk($sformatf("scan_idx_%0d", k), 64'(si4), 64'(k % 5));
            chk($sformatf("scan_data_%0d", k), 64'(sd4), 64'(10 + (k % 5)));
        end
        scan_tick4 = 1'b0;
        step();
        chk("scan_valid_drop", 64'(sv4), 64'h0);

        // Tick coincident with CLR sees the old W
        scan_tick4 = 1'b1;
        do_op(0, OP_CLR, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0);
        scan_tick4 = 1'b0;
        chk("clr_scan_idx", 64'(si4), 64'h2);
        chk("clr_scan_data", 64'(sd4), 64'hc);
        chk("clr_wm", 64'(wm4), 64'h0);
        chk("clr_wp", 64'(wp4), 64'h0);

        // Reset during PLA_WAIT discards the pending digit
        do_op(0, OP_SHIFT, 4'd9, 4'd5, 4'd0, 1'b0, 1'b0);
        chk("pre_rst_wp", 64'(wp4), 64'h500000000);
        do_op(0, OP_DTW, 4'd9, 4'd0, 4'd0, 1'b0, 1'b0);
        chk("pre_rst_rdy", 64'(if4.op_ready), 64'h0);
        reset = 1'b1;
        step();
        chk("midrst_wp", 64'(wp4), 64'h0);
        chk("midrst_wm", 64'(wm4), 64'h0);
        chk("midrst_rdy", 64'(if4.op_ready), 64'h1);
        chk("midrst_sd", 64'(sd4), 64'h0);
        chk("midrst_si", 64'(si4), 64'h0);
        reset = 1'b0;
        step(); step();
        chk("postrst_wp", 64'(wp4), 64'h0);
        chk("postrst_rdy", 64'(if4.op_ready), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/w_shift_unit.md
# w_shift_unit

Parametrised LCD W-shifter successor to the CPU core's inline W/W' logic. Holds a staging register W' and a display register W of DEPTH entries, each NIBBLE_WIDTH bits wide. Entries are loaded by shift, PLA-digit and copy ops issued by the instruction decoder. A free-running scan engine streams W to the segment driver. One instance covers the SM510 binary W (NIBBLE_WIDTH=1, DEPTH=8) and the SM5a nibble W' (NIBBLE_WIDTH=4, DEPTH=9).

## Interface
Parameters:
- NIBBLE_WIDTH, 4: bits per entry; 1 or 4. The PLA ops are only effective at 4.
- DEPTH, 9: number of physical entries, 2..15.

Ports:
- clk  in  1  core clock; one clock domain.
- reset  in  1  synchronous, active-high.
- op_valid  in  1  op request.
- op_ready  out  1  op accepted when op_valid && op_ready.
- op  in  3  0 NOP, 1 SHIFT, 2 DTW, 3 PDTW, 4 TW, 5 PTW, 6 CLR, 7 reserved (treated as NOP).
- w_length  in  4  active length; sampled at acceptance.
- shift_in  in  NIBBLE_WIDTH  value shifted in by SHIFT.
- acc  in  4  accumulator, PLA index low bits.
- lcd_cn  in  1  PLA index bit 4.
- m_prime  in  1  PLA OR-in flag.
- scan_tick  in  1  single-cycle scan advance strobe.
- w_main_flat  out  DEPTH*NIBBLE_WIDTH  W; entry i at [i*NW +: NW].
- w_prime_flat  out  DEPTH*NIBBLE_WIDTH  W'.
- scan_data  out  NIBBLE_WIDTH  scanned W entry.
- scan_idx  out  4  index of scan_data.
- scan_valid  out  1  one-cycle pulse per scanned entry.

## Operation
- Effective length L = w_length if 2 ≤ w_length ≤ DEPTH, else DEPTH.
- Entries at index ≥ L are never modified by any op except CLR.
- SHIFT(v): W'[i] ← W'[i+1] for i in 0..L-2; W'[L-1] ← v.
- DTW: digit = PLA[{lcd_cn, acc}] | {3'b0, ~lcd_cn & m_prime}; then SHIFT(digit).
- PDTW: W'[L-2] ← W'[L-1]; W'[L-1] ← digit. Other entries are unchanged.
- TW: W[i] ← W'[i] for i < L.
- PTW: W[L-1] ← W'[L-1]; W[L-2] ← W'[L-2].
- CLR: all entries of W and W' ← 0.
- When NIBBLE_WIDTH=1, DTW and PDTW are accepted and make no change.
- acc, lcd_cn, m_prime, shift_in and w_length are captured at acceptance. Later changes do not affect an op in flight.
- Scan engine, on scan_tick:
  - If scan_ptr ≥ L, it is treated as 0.
  - scan_data ← W[ptr]; scan_idx ← ptr; scan_valid ← 1 for one cycle.
  - ptr ← (ptr == L-1) ? 0 : ptr+1.
  - The scan runs independently of op processing.

FSM with states IDLE and PLA_WAIT:
- IDLE: op_ready=1. Accepted DTW/PDTW (at NIBBLE_WIDTH=4) → PLA_WAIT. All other ops complete in IDLE.
- PLA_WAIT: op_ready=0; the registered PLA digit is applied to W' → IDLE. op_valid is ignored in this state.

## Timing
- Reset values: W, W', scan_ptr, scan_data, scan_idx, scan_valid all 0; FSM IDLE; op_ready=1.
- SHIFT/TW/PTW/CLR accepted in cycle N: result visible on the flat outputs in N+1. Back-to-back every cycle.
- DTW/PDTW accepted in N: the PLA ROM output is registered at the end of N. op_ready=0 in N+1. W' updated at the end of N+1 and visible in N+2. op_ready=1 again in N+2.
- scan_tick in cycle N: scan_data/scan_idx/scan_valid valid in N+1.
- scan_tick coincident with an op writing W: the scan returns the pre-op W value.
- Reset asserted mid-PLA_WAIT: the pending digit is discarded and all state returns to reset values the next cycle.
- scan_tick with L changing: the wrap compare uses the L of that cycle (the last-accepted w_length).

## Structure
- Package w_unit_pkg holds:
  - w_op_e enum (3-bit encodings above).
  - PLA_TABLE: 32×4-bit constant, indices 0..31 = e,0,c,8,2,a,e,2,e,a,0,0,2,a,2,2,b,9,7,f,d,e,e,b,f,f,4,0,d,e,4,0.
  - MAX_DEPTH = 15.
- Sub-module w_pla_rom: registered 32×4 lookup from PLA_TABLE. Port-level: clk, addr[4:0], data[3:0]. No reset required.
- Top level: FSM, W/W' arrays, scan counter.

## Test plan
- Reset, then SHIFT 1,2,...,9 with L=9 → W' = {1..9}, entry 0 = 1. TW → w_main_flat equals w_prime_flat next cycle.
- DTW with acc=3, lcd_cn=0, m_prime=1, L=9 → op_ready low exactly one cycle; W'[8]=4'h9, and prior entries shift down.
- PDTW with acc=0x10 index (lcd_cn=1, acc=0), L=4 → W'[2]=old W'[3], W'[3]=4'hb; W'[0..1] and W'[4..8] unchanged.
- w_length=1 and w_length=12 with DEPTH=9 → both behave as L=9. NIBBLE_WIDTH=1/DEPTH=8: SHIFT bits 1,0,1 → W'[7:5]=1,0,1; DTW makes no change and op_ready stays 1.
- 12 scan_ticks with L=5 after TW of {a,b,c,d,e} → scan_idx sequence 0..4,0..4,0,1 and scan_data matches. A tick coincident with CLR returns the old value.
- Reset asserted in PLA_WAIT → next cycle all outputs 0 and op_ready=1; the digit is not written.
